iommu_msi_pte_addr_gen: RTL and testbench

//  Iterative, parametrised MSI address-match and vIMSIC-number extraction unit for the IOMMU MSI translation path.

---
 rtl/iommu_msi_pte_addr_gen.sv | 157 +++++++++++++++
 tb/tb_iommu_msi_pte_addr_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/iommu_msi_pte_addr_gen.sv
// Iterative MSI window match and interrupt-file number extraction for the IOMMU MSI path.
// A request is latched in IDLE, compressed STEP mask bits per cycle in BUSY, and the
// resulting MSI PTE address is held in DONE until the response handshake completes.
module iommu_msi_pte_addr_gen #(
  parameter int unsigned MASK_LEN = 52,
  parameter int unsigned STEP     = 4,
  parameter int unsigned PPN_W    = 44,
  parameter int unsigned PA_W     = 56
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [MASK_LEN-1:0] gpaddr_i,
  input  logic [MASK_LEN-1:0] msi_mask_i,
  input  logic [MASK_LEN-1:0] msi_pattern_i,
  input  logic [3:0]          msiptp_mode_i,
  input  logic [PPN_W-1:0]    msiptp_ppn_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_is_msi_o,
  output logic                rsp_err_o,
  output logic [MASK_LEN-1:0] rsp_imsic_num_o,
  output logic [PA_W-1:0]     rsp_pte_addr_o
);

  localparam int unsigned NumChunks = MASK_LEN / STEP;
  localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned IdxW      = $clog2(MASK_LEN + 1);

  if ((MASK_LEN % STEP) != 0) begin : g_step_chk
    $error("MASK_LEN must be a multiple of STEP");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [MASK_LEN-1:0] gpa_q, gpa_d;    // masked-off view shifts right one chunk per cycle
  logic [MASK_LEN-1:0] mask_q, mask_d;
  logic [PPN_W-1:0]    ppn_q, ppn_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [MASK_LEN-1:0] acc_q, acc_d;
  logic                is_msi_q, is_msi_d;
  logic                err_q, err_d;
  logic [MASK_LEN-1:0] imsic_q, imsic_d;
  logic [PA_W-1:0]     pte_q, pte_d;

  logic                match;
  logic [MASK_LEN-1:0] acc_v;
  logic [IdxW-1:0]     idx_v;

  assign match           = ((gpaddr_i ^ msi_pattern_i) & ~msi_mask_i) == '0;
  assign req_ready_o     = (state_q == StIdle);
  assign rsp_valid_o     = (state_q == StDone);
  assign rsp_is_msi_o    = is_msi_q;
  assign rsp_err_o       = err_q;
  assign rsp_imsic_num_o = imsic_q;
  assign rsp_pte_addr_o  = pte_q;

  // Next-state: accept/classify in IDLE, compress one chunk per BUSY cycle, wait in DONE.
  always_comb begin
    state_d  = state_q;
    gpa_d    = gpa_q;
    mask_d   = mask_q;
    ppn_d    = ppn_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    is_msi_d = is_msi_q;
    err_d    = err_q;
    imsic_d  = imsic_q;
    pte_d    = pte_q;
    acc_v    = acc_q;
    idx_v    = idx_q;

    // Each selected mask bit deposits its GPA bit at the next packed position.
    for (int unsigned i = 0; i < STEP; i++) begin
      if (mask_q[i]) begin
        acc_v = acc_v | (MASK_LEN'(gpa_q[i]) << idx_v);
        idx_v = idx_v + IdxW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          gpa_d    = gpaddr_i;
          mask_d   = msi_mask_i;
          ppn_d    = msiptp_ppn_i;
          cnt_d    = '0;
          idx_d    = '0;
          acc_d    = '0;
          is_msi_d = 1'b0;
          err_d    = 1'b0;
          imsic_d  = '0;
          pte_d    = '0;
          if (msiptp_mode_i == 4'd1 && match) begin
            state_d = StBusy;
          end else begin
            state_d = StDone;
            err_d   = (msiptp_mode_i > 4'd1);
          end
        end
      end
      StBusy: begin
        gpa_d  = gpa_q >> STEP;
        mask_d = mask_q >> STEP;
        acc_d  = acc_v;
        idx_d  = idx_v;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NumChunks - 1)) begin
          state_d  = StDone;
          is_msi_d = 1'b1;
          imsic_d  = acc_v;
          pte_d    = PA_W'({ppn_q, 12'b0}) + PA_W'({acc_v, 4'b0});
        end
      end
      StDone: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      gpa_q    <= '0;
      mask_q   <= '0;
      ppn_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      is_msi_q <= 1'b0;
      err_q    <= 1'b0;
      imsic_q  <= '0;
      pte_q    <= '0;
    end else begin
      state_q  <= state_d;
      gpa_q    <= gpa_d;
      mask_q   <= mask_d;
      ppn_q    <= ppn_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      is_msi_q <= is_msi_d;
      err_q    <= err_d;
      imsic_q  <= imsic_d;
      pte_q    <= pte_d;
    end
  end

endmodule

// File: tb/tb_iommu_msi_pte_addr_gen.sv
// Directed bench for iommu_msi_pte_addr_gen with a response scoreboard.
module tb_iommu_msi_pte_addr_gen;

  localparam int unsigned MaskLen = 52;
  localparam int unsigned PpnW    = 44;
  localparam int unsigned PaW     = 56;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               req_valid_i;
  logic               req_ready_o;
  logic [MaskLen-1:0] gpaddr_i;
  logic [MaskLen-1:0] msi_mask_i;
  logic [MaskLen-1:0] msi_pattern_i;
  logic [3:0]         msiptp_mode_i;
  logic [PpnW-1:0]    msiptp_ppn_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic               rsp_is_msi_o;
  logic               rsp_err_o;
  logic [MaskLen-1:0] rsp_imsic_num_o;
  logic [PaW-1:0]     rsp_pte_addr_o;

  iommu_msi_pte_addr_gen dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .gpaddr_i        (gpaddr_i),
    .msi_mask_i      (msi_mask_i),
    .msi_pattern_i   (msi_pattern_i),
    .msiptp_mode_i   (msiptp_mode_i),
    .msiptp_ppn_i    (msiptp_ppn_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_is_msi_o    (rsp_is_msi_o),
    .rsp_err_o       (rsp_err_o),
    .rsp_imsic_num_o (rsp_imsic_num_o),
    .rsp_pte_addr_o  (rsp_pte_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic               is_msi;
    logic               err;
    logic [MaskLen-1:0] num;
    logic [PaW-1:0]     pte;
    int                 lat;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference extraction: pack GPA bits selected by the mask, LSB first.
  function automatic logic [MaskLen-1:0] extract(input logic [MaskLen-1:0] g,
                                                 input logic [MaskLen-1:0] m);
    logic [MaskLen-1:0] r;
    int                 k;
    r = '0;
    k = 0;
    for (int i = 0; i < MaskLen; i++) begin
      if (m[i]) begin
        r[k] = g[i];
        k++;
      end
    end
    return r;
  endfunction

  // Drive one request; leaves the bench 1 time unit into cycle 1 after the accept edge.
  task automatic issue(input logic [MaskLen-1:0] g, input logic [MaskLen-1:0] m,
                       input logic [MaskLen-1:0] p, input logic [3:0] mode,
                       input logic [PpnW-1:0] ppn, input bit push);
    exp_t e;
    logic hit;
    @(negedge clk_i);
    check("req_ready_idle", 64'(req_ready_o), 64'd1);
    gpaddr_i      = g;
    msi_mask_i    = m;
    msi_pattern_i = p;
    msiptp_mode_i = mode;
    msiptp_ppn_i  = ppn;
    req_valid_i   = 1'b1;
    hit      = (((g ^ p) & ~m) == '0);
    e.err    = (mode != 4'd0) && (mode != 4'd1);
    e.is_msi = (mode == 4'd1) && hit;
    e.num    = e.is_msi ? extract(g, m) : '0;
    e.pte    = e.is_msi ? (PaW'({ppn, 12'h000}) + PaW'({e.num, 4'h0})) : '0;
    e.lat    = e.is_msi ? 14 : 1;
    if (push) sb.push_back(e);
    @(posedge clk_i);
    #1;
    // Scramble inputs to show they were latched.
    req_valid_i   = 1'b0;
    gpaddr_i      = ~g;
    msi_mask_i    = ~m;
    msi_pattern_i = ~p;
    msiptp_mode_i = ~mode;
    msiptp_ppn_i  = ~ppn;
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall, then handshake.
  task automatic collect(input string tag, input int hold);
    exp_t e;
    int   lat;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk_i);
      lat++;
      if (rsp_valid_o) break;
    end
    check({tag, "_valid"}, 64'(rsp_valid_o), 64'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    if (!rsp_valid_o) return;
    check({tag, "_latency"}, 64'(lat), 64'(e.lat));
    check({tag, "_is_msi"}, 64'(rsp_is_msi_o), 64'(e.is_msi));
    check({tag, "_err"}, 64'(rsp_err_o), 64'(e.err));
    check({tag, "_imsic"}, 64'(rsp_imsic_num_o), 64'(e.num));
    check({tag, "_pte"}, 64'(rsp_pte_addr_o), 64'(e.pte));
    check({tag, "_req_ready_busy"}, 64'(req_ready_o), 64'd0);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk_i);
      check({tag, "_hold_valid"}, 64'(rsp_valid_o), 64'd1);
      check({tag, "_hold_req_ready"}, 64'(req_ready_o), 64'd0);
      check({tag, "_hold_imsic"}, 64'(rsp_imsic_num_o), 64'(e.num));
      check({tag, "_hold_pte"}, 64'(rsp_pte_addr_o), 64'(e.pte));
      check({tag, "_hold_is_msi"}, 64'(rsp_is_msi_o), 64'(e.is_msi));
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_post_valid"}, 64'(rsp_valid_o), 64'd0);
    check({tag, "_post_req_ready"}, 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    bit seen;
    rst_i         = 1'b1;
    req_valid_i   = 1'b0;
    rsp_ready_i   = 1'b0;
    gpaddr_i      = '0;
    msi_mask_i    = '0;
    msi_pattern_i = '0;
    msiptp_mode_i = '0;
    msiptp_ppn_i  = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    @(negedge clk_i);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_is_msi", 64'(rsp_is_msi_o), 64'd0);
    check("rst_err", 64'(rsp_err_o), 64'd0);
    check("rst_imsic", 64'(rsp_imsic_num_o), 64'd0);
    check("rst_pte", 64'(rsp_pte_addr_o), 64'd0);

    // Contiguous mask hit.
    issue(52'h28005, 52'h7, 52'h28000, 4'd1, 44'h80000, 1'b1);
    collect("t1", 0);
    check("t1_const", 64'h8000_0050, 64'(PaW'({44'h80000, 12'h000}) + PaW'({52'd5, 4'h0})));

    // Non-contiguous mask compression.
    issue(52'h28080, 52'h0A0, 52'h28000, 4'd1, 44'h80000, 1'b1);
    collect("t2", 0);

    // Window miss.
    issue(52'h29005, 52'h7, 52'h28000, 4'd1, 44'h80000, 1'b1);
    collect("t3", 0);

    // Mode Off and reserved mode.
    issue(52'h28005, 52'h7, 52'h28000, 4'd0, 44'h80000, 1'b1);
    collect("t4_off", 0);
    issue(52'h28005, 52'h7, 52'h28000, 4'd3, 44'h80000, 1'b1);
    collect("t4_rsvd", 0);

    // Stalled response, then immediate next request.
    issue(52'h28005, 52'h7, 52'h28000, 4'd1, 44'h80000, 1'b1);
    collect("t5", 5);
    issue(52'h28003, 52'h7, 52'h28000, 4'd1, 44'h80000, 1'b1);
    collect("t5_next", 0);

    // Mask boundaries: zero mask and all-ones mask with PPN wrap.
    issue(52'h12345, 52'h0, 52'h12345, 4'd1, 44'h00ABC, 1'b1);
    collect("mask_zero", 0);
    issue(52'hF_EDCB_A987_6543, {MaskLen{1'b1}}, 52'h0, 4'd1, 44'hFFF_FFFF_FFFF, 1'b1);
    collect("mask_ones", 0);

    // Reset during BUSY cycle 6 drops the request.
    issue(52'h28005, 52'h7, 52'h28000, 4'd1, 44'h80000, 1'b0);
    repeat (5) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("t6_valid_after_rst", 64'(rsp_valid_o), 64'd0);
    check("t6_ready_after_rst", 64'(req_ready_o), 64'd1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen = 1'b1;
    end
    check("t6_no_response", 64'(seen), 64'd0);
    issue(52'h28005, 52'h7, 52'h28000, 4'd1, 44'h80000, 1'b1);
    collect("t6_after", 0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
